sort_sequencer: RTL and testbench
=================================

// Module: sort_sequencer
// PURPOSE
//  Sequential controller that time-multiplexes one compare-exchange unit to sort a frame of N unsigned words.
//  Accepts a frame on a valid/ready input stream and buffers it in an internal register array.
//  Sequences bubble-sort passes at one compare per cycle, then streams the frame out in ascending order.
//  Sits between a producer and a consumer wherever the fully combinational sorter is too large.
// PARAMETERS
//  N  10  words per frame (>=2)
//  W  32  word width in bits, compared unsigned
// PORTS
//  clk        in   1  single clock, all logic rising-edge
//  rst_n      in   1  reset, synchronous, active-low
//  in_valid   in   1  input word valid
//  in_ready   out  1  high only in LOAD
//  in_data    in   W  input word
//  out_valid  out  1  output word valid, high only in DRAIN
//  out_ready  in   1  consumer accepts output word
//  out_data   out  W  sorted word; index 0 is the smallest
//  out_last   out  1  high with out_valid on word N-1
//  busy       out  1  high in SORT or DRAIN
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=LOAD, counters=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
//  The array contents are don't-care after reset.
//  LOAD:  on in_valid&in_ready, mem[wr]<=in_data and wr++. Gaps in in_valid are allowed.
//         After accepting word N-1, go to SORT next cycle; in_ready drops in that same cycle.
//  SORT:  one compare per cycle on pair (j, j+1). If mem[j]>mem[j+1], swap them and set swapped=1.
//         Equal values are never swapped (stable).
//         j runs 0..N-2-pass. At the end of a pass, pass++, j=0, swapped cleared.
//         After pass N-2 completes, go to DRAIN.
//         Full sort takes exactly N*(N-1)/2 cycles (45 for N=10). in_valid is ignored.
//  DRAIN: out_valid=1, out_data=mem[rd]. On out_valid&out_ready, rd++.
//         out_data/out_last hold stable while out_ready=0.
//         Accept of word N-1 (out_last=1) goes to LOAD next cycle with wr=rd=0.
//  Latency: last input accept at edge t; first compare in cycle t+1; out_valid rises at t+1+45 for N=10.
//  Reset mid-SORT/DRAIN: frame discarded, outputs to reset values, no partial output.
//  Back-to-back frames: no overlap; the next frame loads only after the current one fully drains.
//  Index counters are sized $clog2(N). No counter wraps past N-1.
// CONFIGURATION
//  SORT_EARLY_EXIT_EN defined:
//    When a pass completes with swapped==0, go directly to DRAIN.
//    Sorted input takes N-1 cycles (one pass).
//  SORT_EARLY_EXIT_EN undefined:
//    Always runs all N-1 passes, a fixed N*(N-1)/2 cycles. No swapped flag is implemented.
//  Output values are identical in both builds; only latency differs.
// STRUCTURE
//  Package sort_pkg: state enum sort_state_e {S_LOAD, S_SORT, S_DRAIN}, defaults SORT_N=10, SORT_W=32.
//  Sub-module sort_cmp_swap: combinational (a,b) -> (lo,hi,swap), unsigned, swap only if a>b.
//  The top level holds the FSM, the wr/j/pass/rd counters, and the register array mem[0:N-1].
// TESTING
//  1. Load 9,8,...,0 with in_valid held high and out_ready=1.
//     -> out 0,1,...,9; out_last with 9; exactly 45 SORT cycles (both builds).
//  2. Load 0..9, already sorted.
//     -> out 0..9; SORT lasts 9 cycles with SORT_EARLY_EXIT_EN, 45 without.
//  3. Load FFFFFFFF,0,5,5,80000000,1,FFFFFFFE,5,7,2.
//     -> 0,1,2,5,5,5,7,80000000,FFFFFFFE,FFFFFFFF (unsigned ordering).
//  4. Random in_valid gaps in LOAD; out_ready toggled 50% in DRAIN.
//     -> no drop or duplicate; out_data stable under stall; in_ready=0 while busy.
//  5. rst_n=0 for one cycle mid-SORT, then a new frame 3,1,2,...
//     -> out_valid=0 right after reset; the new frame sorts correctly with no stale words.
//  6. Two frames back-to-back.
//     -> in_ready rises the cycle after the first frame's out_last accept; the second frame sorts independently.

Source files
------------

// File: rtl/sort_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_pkg                                                      |
// | Brief    : Shared types and default sizes for the sort sequencer slice.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package sort_pkg;

  localparam int SORT_N = 10;
  localparam int SORT_W = 32;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } sort_state_e;

endpackage
`default_nettype wire

// File: rtl/sort_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_sequencer_if                                             |
// | Brief    : Input/output streams and status of the sort sequencer.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface sort_sequencer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  // Sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/sort_sequencer_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_cmp_swap                                                 |
// | Brief    : Unsigned compare-exchange; swaps only when a > b (stable).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sort_cmp_swap #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  output logic      [W-1:0] lo,
  output logic      [W-1:0] hi,
  output logic              swap
);
  // Strict greater-than keeps equal words in their original order
  always_comb begin
    swap = (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_sequencer                                                |
// | Brief    : Buffers an N-word frame, bubble-sorts it one compare per      |
// |            cycle through a single compare-exchange unit, then streams it |
// |            out in ascending unsigned order.                              |
// |            Optional macro SORT_EARLY_EXIT_EN: leave SORT after the first |
// |            pass that makes no swap.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  sort_sequencer_if.slave  bus
);

  localparam int                c_iw   = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_iw-1:0]   c_last = c_iw'(N - 1);
  localparam logic [c_iw-1:0]   c_n_m2 = c_iw'(N - 2);

  sort_state_e      r_state;
  sort_state_e      w_state_nxt;
  logic [c_iw-1:0]  r_wr;
  logic [c_iw-1:0]  r_j;
  logic [c_iw-1:0]  r_pass;
  logic [c_iw-1:0]  r_rd;
  logic [W-1:0]     r_mem [N];

  logic [c_iw-1:0]  w_j_nxt;
  logic [W-1:0]     w_lo;
  logic [W-1:0]     w_hi;
  logic             w_swap;
  logic             w_accept_in;
  logic             w_accept_out;
  logic             w_pass_end;
  logic             w_sort_done;

`ifdef SORT_EARLY_EXIT_EN
  logic             r_swapped;
`endif

  assign w_j_nxt      = r_j + 1'b1;
  assign w_accept_in  = (r_state == S_LOAD)  && bus.in_valid;
  assign w_accept_out = (r_state == S_DRAIN) && bus.out_ready;
  // Pass p compares pairs 0..N-2-p; the top p words are already final
  assign w_pass_end   = (r_j == (c_n_m2 - r_pass));
`ifdef SORT_EARLY_EXIT_EN
  assign w_sort_done  = w_pass_end && ((r_pass == c_n_m2) || !(r_swapped || w_swap));
`else
  assign w_sort_done  = w_pass_end && (r_pass == c_n_m2);
`endif

  sort_cmp_swap #(.W(W)) u_cmp (
    .a    (r_mem[r_j]),
    .b    (r_mem[w_j_nxt]),
    .lo   (w_lo),
    .hi   (w_hi),
    .swap (w_swap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state: frame full -> sort, sort finished -> drain, last word taken -> load
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept_in && (r_wr == c_last))  w_state_nxt = S_SORT;
      S_SORT:  if (w_sort_done)                       w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_accept_out && (r_rd == c_last))  w_state_nxt = S_LOAD;
      default:                                        w_state_nxt = S_LOAD;
    endcase
  end

  // Outputs are decoded from state only, so they hold steady under stall
  always_comb begin
    bus.in_ready  = (r_state == S_LOAD);
    bus.out_valid = (r_state == S_DRAIN);
    bus.out_data  = (r_state == S_DRAIN) ? r_mem[r_rd] : '0;
    bus.out_last  = (r_state == S_DRAIN) && (r_rd == c_last);
    bus.busy      = (r_state == S_SORT) || (r_state == S_DRAIN);
  end

  // Index counters; each returns to zero as its phase ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_j    <= '0;
      r_pass <= '0;
      r_rd   <= '0;
`ifdef SORT_EARLY_EXIT_EN
      r_swapped <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept_in) r_wr <= (r_wr == c_last) ? '0 : r_wr + 1'b1;
        end
        S_SORT: begin
          if (w_pass_end) begin
            r_j    <= '0;
            r_pass <= w_sort_done ? '0 : r_pass + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            r_swapped <= 1'b0;
`endif
          end else begin
            r_j <= w_j_nxt;
`ifdef SORT_EARLY_EXIT_EN
            r_swapped <= r_swapped | w_swap;
`endif
          end
        end
        S_DRAIN: begin
          if (w_accept_out) r_rd <= (r_rd == c_last) ? '0 : r_rd + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame storage: written on input accept, rewritten on compare-exchange
  always_ff @(posedge clk) begin
    if (w_accept_in) begin
      r_mem[r_wr] <= bus.in_data;
    end else if ((r_state == S_SORT) && w_swap) begin
      r_mem[r_j]     <= w_lo;
      r_mem[w_j_nxt] <= w_hi;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sort_sequencer                                             |
// | Brief    : Self-checking bench for sort_sequencer against a queue-sort   |
// |            reference. Honors SORT_EARLY_EXIT_EN for SORT latency.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sort_sequencer;
  import sort_pkg::*;

  localparam int N = SORT_N;
  localparam int W = SORT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] fr [N];

  sort_sequencer_if #(.W(W)) bus ();

  sort_sequencer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bubble sort makes as many swapping passes as the largest count of bigger
  // words sitting left of any word; early exit adds one clean pass (capped).
  function automatic int exp_sort_cycles();
    int k, cnt, passes, cyc;
    k = 0;
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      for (int m = 0; m < i; m++) if (fr[m] > fr[i]) cnt++;
      if (cnt > k) k = cnt;
    end
`ifdef SORT_EARLY_EXIT_EN
    passes = (k + 1 > N - 1) ? N - 1 : k + 1;
`else
    passes = N - 1;
`endif
    cyc = 0;
    for (int p = 0; p < passes; p++) cyc += N - 1 - p;
    return cyc;
  endfunction

  task automatic load_frame(input bit gaps);
    int g;
    for (int i = 0; i < N; i++) begin
      g = 0;
      while (gaps && ($urandom_range(0, 2) == 0) && (g < 5)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        @(negedge clk);
        g++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      check("in_ready_load", W'(bus.in_ready), W'(1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sort_and_drain(input bit stalls);
    logic [W-1:0] q [$];
    int  cyc, budget;
    bit  acc;
    cyc = 0;
    while (!bus.out_valid && (cyc < 200)) begin
      check("in_ready_busy", W'(bus.in_ready), W'(0));
      check("busy_sort", W'(bus.busy), W'(1));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = $urandom;
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("sort_cycles", W'(cyc), W'(exp_sort_cycles()));

    q = {};
    for (int i = 0; i < N; i++) q.push_back(fr[i]);
    q.sort();

    for (int i = 0; i < N; i++) begin
      acc = 1'b0;
      budget = 0;
      while (!acc && (budget < 50)) begin
        bus.out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
        check("out_valid", W'(bus.out_valid), W'(1));
        check("out_data", bus.out_data, q[i]);
        check("out_last", W'(bus.out_last), W'(i == N - 1));
        check("in_ready_drain", W'(bus.in_ready), W'(0));
        acc = bus.out_ready && bus.out_valid;
        @(negedge clk);
        budget++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $error("FAIL drain_timeout: observed no accept expected word %0d", i);
        break;
      end
    end
    bus.out_ready = 1'b0;
    check("in_ready_after", W'(bus.in_ready), W'(1));
    check("out_valid_after", W'(bus.out_valid), W'(0));
    check("busy_after", W'(bus.busy), W'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_last", W'(bus.out_last), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Descending input
    for (int i = 0; i < N; i++) fr[i] = W'(N - 1 - i);
    load_frame(1'b0);
    sort_and_drain(1'b0);

    // Already sorted
    for (int i = 0; i < N; i++) fr[i] = W'(i);
    load_frame(1'b0);
    sort_and_drain(1'b0);

    // Extremes and duplicates
    fr[0] = 32'hFFFF_FFFF; fr[1] = 32'h0;        fr[2] = 32'h5;        fr[3] = 32'h5;
    fr[4] = 32'h8000_0000; fr[5] = 32'h1;        fr[6] = 32'hFFFF_FFFE; fr[7] = 32'h5;
    fr[8] = 32'h7;         fr[9] = 32'h2;
    load_frame(1'b0);
    sort_and_drain(1'b0);

    // Random data, input gaps, output stalls
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) fr[i] = (f == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
      load_frame(1'b1);
      sort_and_drain(1'b1);
    end

    // Reset in the middle of SORT discards the frame
    for (int i = 0; i < N; i++) fr[i] = W'($urandom);
    load_frame(1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_in_ready", W'(bus.in_ready), W'(1));
    check("midrst_busy", W'(bus.busy), W'(0));
    check("midrst_out_data", bus.out_data, '0);
    fr[0] = 3; fr[1] = 1; fr[2] = 2;
    for (int i = 3; i < N; i++) fr[i] = W'(100 - i);
    load_frame(1'b0);
    sort_and_drain(1'b1);

    // Back-to-back frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) fr[i] = W'($urandom);
      load_frame(1'b0);
      sort_and_drain(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
